spi_slave_if: RTL and testbench

SPI responder (slave) endpoint: the far end of the SPI master driven from the APB TX/RX FIFO path.
- Oversamples SCLK, CS_N and MOSI in the PCLK domain and deserialises MOSI into DWIDTH-bit words with a write strobe.
- Serialises a one-entry TX holding register onto MISO.
- Used as a loopback target for the SPI master and as a standalone peripheral front-end.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync.sv | 20 ++
 rtl/spi_sync_edge.sv | 27 ++
 rtl/spi_slave_if.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM state encoding,
// SCLK edge-direction derivation and bit-counter sizing.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Leading edge leaves the idle level, trailing edge returns to it.
    function automatic logic lead_edge(input int cpol);
        return (cpol == 0) ? EDGE_RISE : EDGE_FALL;
    endfunction

    function automatic logic trail_edge(input int cpol);
        return (cpol == 0) ? EDGE_FALL : EDGE_RISE;
    endfunction

    function automatic int cnt_width(input int dwidth);
        return (dwidth > 2) ? $clog2(dwidth) : 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    // Deliberately not reset: a mid-frame reset must not fabricate a CS_N
    // edge from the flops being forced to an idle value.
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_sync_edge.sv
// Synchroniser followed by rise/fall detection against a one-cycle delayed copy.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync_s;
    logic prev_q;

    spi_sync #(.STAGES(STAGES)) u_sync (
        .clk_i (clk_i),
        .d_i   (d_i),
        .q_o   (sync_s)
    );

    always_ff @(posedge clk_i) begin
        prev_q <= sync_s;
    end

    assign rise_o = sync_s & ~prev_q;
    assign fall_o = ~sync_s & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder: oversamples SCLK/CS_N/MOSI in the PCLK domain, deserialises
// MOSI into words and serialises a one-entry TX holding register onto MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int   CW       = cnt_width(DWIDTH);
    localparam logic LEAD_DIR = lead_edge(CPOL);
    localparam logic TRL_DIR  = trail_edge(CPOL);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic lead_ev, trail_ev, sample_ev, shift_ev;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk_i (PCLK), .d_i (SCLK), .rise_o (sclk_rise), .fall_o (sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn (
        .clk_i (PCLK), .d_i (CS_N), .rise_o (cs_rise), .fall_o (cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk_i (PCLK), .d_i (MOSI), .q_o (mosi_s)
    );

    assign lead_ev   = (LEAD_DIR == EDGE_RISE) ? sclk_rise : sclk_fall;
    assign trail_ev  = (TRL_DIR == EDGE_RISE) ? sclk_rise : sclk_fall;
    assign sample_ev = (CPHA == 0) ? lead_ev : trail_ev;
    assign shift_ev  = (CPHA == 0) ? trail_ev : lead_ev;

    spi_state_t        state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DWIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DWIDTH-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, miso_d;
    logic [DWIDTH-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              reload;
    logic [DWIDTH-1:0] load_word;

    assign load_word = hold_full_q ? hold_q : '0;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        reload      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                    // CPHA=0 must present the MSB before the first sampling edge.
                    if (CPHA == 0) begin
                        miso_d     = load_word[DWIDTH-1];
                        tx_shift_d = load_word << 1;
                    end else begin
                        tx_shift_d = load_word;
                    end
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    miso_d     = 1'b0;
                    rx_shift_d = '0;
                end else if (sample_ev) begin
                    rx_shift_d = {rx_shift_q[DWIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CW'(DWIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[DWIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        reload     = 1'b1;
                        tx_shift_d = load_word;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_ev) begin
                    miso_d     = tx_shift_q[DWIDTH-1];
                    tx_shift_d = tx_shift_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reload) begin
            hold_full_d = 1'b0;
            underrun_d  = ~hold_full_q;
        end
        // A handshake coinciding with a reload lands after the reload took the old word.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign MISO        = miso_q;
    assign busy        = (state_q == ACTIVE);
    assign MISO_OE     = busy;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_valid_q & ~rx_ready;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a mode-0 instance (index 0) and a CPOL=1/CPHA=1
// instance (index 1) driven by a behavioural SPI master.
module tb_spi_slave_if;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] sclk, cs_n, mosi, miso, miso_oe;
    logic [1:0] tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, tx_underrun, busy;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    always #5 PCLK = ~PCLK;

    spi_slave_if #(.DWIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .SCLK(sclk[0]), .CS_N(cs_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .MISO_OE(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_ready(rx_ready[0]), .rx_overrun(rx_overrun[0]), .tx_underrun(tx_underrun[0]),
        .busy(busy[0])
    );

    spi_slave_if #(.DWIDTH(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .SCLK(sclk[1]), .CS_N(cs_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .MISO_OE(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_ready(rx_ready[1]), .rx_overrun(rx_overrun[1]), .tx_underrun(tx_underrun[1]),
        .busy(busy[1])
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: {overrun, word} expected per completed word.
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int rxv_cnt [2] = '{0, 0};
    int und_cnt [2] = '{0, 0};

    always @(negedge PCLK) begin
        if (rx_valid[0]) begin
            rxv_cnt[0]++;
            if (exp_q0.size() == 0) begin
                checks++;
                $display("FAIL rx0_unexpected: got %0h expected no word", rx_data[0]);
            end else begin
                check("rx0_word", 32'({rx_overrun[0], rx_data[0]}), 32'(exp_q0.pop_front()));
            end
        end else if (rx_overrun[0]) begin
            checks++;
            $display("FAIL rx0_overrun_alone: got 1 expected 0");
        end
        if (tx_underrun[0]) und_cnt[0]++;
    end

    always @(negedge PCLK) begin
        if (rx_valid[1]) begin
            rxv_cnt[1]++;
            if (exp_q1.size() == 0) begin
                checks++;
                $display("FAIL rx1_unexpected: got %0h expected no word", rx_data[1]);
            end else begin
                check("rx1_word", 32'({rx_overrun[1], rx_data[1]}), 32'(exp_q1.pop_front()));
            end
        end
        if (tx_underrun[1]) und_cnt[1]++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        wait_cyc(1);
        PRESET = 1'b1;
        wait_cyc(2);
        PRESET = 1'b0;
        wait_cyc(2);
    endtask

    task automatic load_tx(input int k, input logic [7:0] d);
        int n = 0;
        while (!tx_ready[k] && n < 500) begin
            wait_cyc(1);
            n++;
        end
        if (!tx_ready[k]) begin
            checks++;
            $display("FAIL tx_ready_timeout: got 0 expected 1 within 500 cycles");
        end
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        wait_cyc(1);
        tx_valid[k] = 1'b0;
    endtask

    // Master: half-period of 4 PCLK cycles, bits taken MSB-first from mo[15].
    // oe_lat = cycles from CS_N release until MISO_OE is seen low.
    task automatic frame(input int k, input logic [15:0] mo, input int nbits,
                         output logic [15:0] mi, output int oe_lat);
        logic cpol, cpha;
        cpol = (k == 1);
        cpha = (k == 1);
        mi = '0;
        if (!cpha) mosi[k] = mo[15];
        cs_n[k] = 1'b0;
        wait_cyc(8);
        check("busy_in_frame", 32'({busy[k], miso_oe[k]}), 32'd3);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mi[15-i] = miso[k];
                sclk[k]  = ~cpol;
                wait_cyc(4);
                sclk[k] = cpol;
                if (i + 1 < nbits) mosi[k] = mo[14-i];
                wait_cyc(4);
            end else begin
                sclk[k] = ~cpol;
                mosi[k] = mo[15-i];
                wait_cyc(4);
                mi[15-i] = miso[k];
                sclk[k]  = cpol;
                wait_cyc(4);
            end
        end
        wait_cyc(4);
        cs_n[k] = 1'b1;
        oe_lat = 0;
        while (miso_oe[k] && oe_lat < 16) begin
            wait_cyc(1);
            oe_lat++;
        end
        wait_cyc(8);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic       has_tx;
        logic       rdy;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mi;
        int          lat, u0, r0;

        PRESET      = 1'b1;
        sclk        = 2'b10;
        cs_n        = 2'b11;
        mosi        = 2'b00;
        tx_valid    = 2'b00;
        tx_data[0]  = '0;
        tx_data[1]  = '0;
        rx_ready    = 2'b11;
        wait_cyc(6);
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_oe",       32'(miso_oe),  32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd3);
        check("rst_rx_valid", 32'({rx_valid, rx_overrun, tx_underrun}), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_rx_data",  32'({rx_data[0], rx_data[1]}), 32'd0);
        PRESET = 1'b0;
        wait_cyc(4);

        vecs[0] = '{8'h3C, 8'hA5, 1'b1, 1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{8'hC3, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h00};
        vecs[2] = '{8'h7E, 8'h5A, 1'b1, 1'b0, 8'h7E, 8'h5A};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF};
        for (int r = 4; r < 6; r++) begin
            vecs[r].mosi     = 8'($urandom_range(255));
            vecs[r].tx       = 8'($urandom_range(255));
            vecs[r].has_tx   = 1'($urandom_range(1));
            vecs[r].rdy      = 1'($urandom_range(1));
            vecs[r].exp_rx   = vecs[r].mosi;
            vecs[r].exp_miso = vecs[r].has_tx ? vecs[r].tx : 8'h00;
        end

        // Single mode-0 words; the end-of-word reload always underruns here.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rx_ready[0] = vecs[r].rdy;
            if (vecs[r].has_tx) begin
                load_tx(0, vecs[r].tx);
                check("tx_ready_after_load", 32'(tx_ready[0]), 32'd0);
            end
            u0 = und_cnt[0];
            r0 = rxv_cnt[0];
            exp_q0.push_back({~vecs[r].rdy, vecs[r].exp_rx});
            frame(0, {vecs[r].mosi, 8'h00}, 8, mi, lat);
            check("vec_miso",     32'(mi[15:8]), 32'(vecs[r].exp_miso));
            check("vec_underrun", 32'(und_cnt[0] - u0), vecs[r].has_tx ? 32'd1 : 32'd2);
            check("vec_rx_count", 32'(rxv_cnt[0] - r0), 32'd1);
            check("vec_rx_held",  32'(rx_data[0]), 32'(vecs[r].exp_rx));
            check("vec_tx_ready", 32'(tx_ready[0]), 32'd1);
            rx_ready[0] = 1'b1;
        end

        // Back-to-back words under one CS_N, TX refilled between words.
        do_reset();
        load_tx(0, 8'hFF);
        u0 = und_cnt[0];
        r0 = rxv_cnt[0];
        exp_q0.push_back({1'b0, 8'h01});
        exp_q0.push_back({1'b0, 8'h80});
        fork
            frame(0, {8'h01, 8'h80}, 16, mi, lat);
            begin
                load_tx(0, 8'h00);
                wait_cyc(2);
                load_tx(0, 8'h55);
            end
        join
        check("b2b_miso",     32'(mi), 32'hFF00);
        check("b2b_underrun", 32'(und_cnt[0] - u0), 32'd0);
        check("b2b_rx_count", 32'(rxv_cnt[0] - r0), 32'd2);

        // CS_N released after 5 bits, then a full frame.
        do_reset();
        r0 = rxv_cnt[0];
        frame(0, {8'hA0, 8'h00}, 5, mi, lat);
        check("abort_oe_latency", 32'(lat), 32'd3);
        check("abort_no_rx",      32'(rxv_cnt[0] - r0), 32'd0);
        check("abort_miso",       32'({miso[0], busy[0]}), 32'd0);
        exp_q0.push_back({1'b0, 8'h55});
        frame(0, {8'h55, 8'h00}, 8, mi, lat);
        check("after_abort_rx_count", 32'(rxv_cnt[0] - r0), 32'd1);
        check("after_abort_rx_data",  32'(rx_data[0]), 32'h55);

        // CPOL=1, CPHA=1 instance.
        do_reset();
        load_tx(1, 8'h69);
        exp_q1.push_back({1'b0, 8'h96});
        frame(1, {8'h96, 8'h00}, 8, mi, lat);
        check("m3_miso",    32'(mi[15:8]), 32'h69);
        check("m3_rx_data", 32'(rx_data[1]), 32'h96);

        // Reset in the middle of a CPOL=1/CPHA=1 frame.
        load_tx(1, 8'hF0);
        r0 = rxv_cnt[1];
        fork
            frame(1, {8'hFF, 8'h00}, 8, mi, lat);
            begin
                wait_cyc(40);
                check("m3_busy_before_reset", 32'(busy[1]), 32'd1);
                PRESET = 1'b1;
                wait_cyc(1);
                check("mr_miso",     32'({miso[1], miso_oe[1]}), 32'd0);
                check("mr_tx_ready", 32'(tx_ready[1]), 32'd1);
                check("mr_rx_data",  32'(rx_data[1]), 32'd0);
                check("mr_pulses",   32'({rx_valid[1], rx_overrun[1], tx_underrun[1]}), 32'd0);
                check("mr_busy",     32'(busy[1]), 32'd0);
                PRESET = 1'b0;
            end
        join
        check("mr_no_rx",   32'(rxv_cnt[1] - r0), 32'd0);
        check("mr_idle",    32'(busy[1]), 32'd0);

        check("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
